// File: rtl/seg_scan4.sv
// seg_scan4 -- four-digit time-multiplexed seven-segment scan driver.
//
// Scans four digits round-robin, holding each one for CLK_DIV cycles.
// New display data is staged on load and reaches the shadow register
// only at a frame boundary, so a frame never shows a half-updated value.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   load   in   single-cycle strobe capturing data/dp/blank
//   data   in   [15:0] hex nibbles, [3:0] = digit 0 ... [15:12] = digit 3
//   dp     in   [3:0]  decimal-point request per digit, active-high
//   blank  in   [3:0]  blank request per digit, active-high
//   seg    out  [7:0]  segment bus, active-low; bit 7 = dp, bits 6..0 = g..a
//   en     out  [3:0]  digit enables, active-low; bit n = digit n
//   frame  out  one-cycle pulse following each frame boundary
module seg_scan4 #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [7:0]  seg,
  output logic [3:0]  en,
  output logic        frame
);

  localparam int              CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_d;

  logic [15:0]      r_stg_data;
  logic [3:0]       r_stg_dp;
  logic [3:0]       r_stg_blank;
  logic             r_pend;

  logic [15:0]      r_sh_data;
  logic [3:0]       r_sh_dp;
  logic [3:0]       r_sh_blank;

  logic [7:0]       r_seg;
  logic [3:0]       r_en;
  logic             r_frame;

  logic             w_wrap;
  logic             w_bound;
  logic [3:0]       w_nib;

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_wrap  = (r_cnt == CNT_MAX);
  assign w_bound = w_wrap && (r_d == 2'd3);
  assign w_nib   = r_sh_data[r_d*4 +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_d         <= 2'd0;
      r_stg_data  <= 16'h0000;
      r_stg_dp    <= 4'h0;
      r_stg_blank <= 4'h0;
      r_pend      <= 1'b0;
      r_sh_data   <= 16'h0000;
      r_sh_dp     <= 4'h0;
      r_sh_blank  <= 4'h0;
      r_seg       <= 8'hFF;
      r_en        <= 4'hF;
      r_frame     <= 1'b0;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_d <= r_d + 2'd1;
      r_frame <= w_bound;

      // Latest load always overwrites staging; the pending flag decides
      // whether the boundary actually commits it.
      if (load) begin
        r_stg_data  <= data;
        r_stg_dp    <= dp;
        r_stg_blank <= blank;
      end

      if (w_bound) begin
        // A load landing on the boundary bypasses staging entirely.
        if (load) begin
          r_sh_data  <= data;
          r_sh_dp    <= dp;
          r_sh_blank <= blank;
        end else if (r_pend) begin
          r_sh_data  <= r_stg_data;
          r_sh_dp    <= r_stg_dp;
          r_sh_blank <= r_stg_blank;
        end
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend <= 1'b1;
      end

      // cnt==0 is a guard cycle with all digits off, preventing ghosting
      // while the shared segment bus changes to the next digit.
      if ((r_cnt == '0) || r_sh_blank[r_d]) begin
        r_en  <= 4'hF;
        r_seg <= 8'hFF;
      end else begin
        r_en  <= ~(4'b0001 << r_d);
        r_seg <= {~r_sh_dp[r_d], seg7_decode(w_nib)};
      end
    end
  end

  assign seg   = r_seg;
  assign en    = r_en;
  assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan4.sv
// Directed testbench for seg_scan4 with CLK_DIV=4 (16-cycle frame).
module tb_seg_scan4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [7:0]  seg;
  logic [3:0]  en;
  logic        frame;

  int n_vec;
  int n_err;

  seg_scan4 #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (data),
    .dp    (dp),
    .blank (blank),
    .seg   (seg),
    .en    (en),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    load  = 1'b1;
    data  = d;
    dp    = p;
    blank = b;
    step();
    load  = 1'b0;
  endtask

  // Step until frame is seen high, bounded.
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called at a sample where frame was just seen high (or right after
  // reset release); checks the following 16 samples, which make up one
  // full scan ending on the next frame pulse.
  task automatic check_frame(input string tag,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic [3:0] blk);
    logic [7:0] exp_seg;
    logic [3:0] exp_en;
    int         dg;
    for (int i = 0; i < 16; i++) begin
      step();
      dg = i / 4;
      if ((i % 4) == 0 || blk[dg]) begin
        exp_en  = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        case (dg)
          0: begin exp_en = 4'hE; exp_seg = s0; end
          1: begin exp_en = 4'hD; exp_seg = s1; end
          2: begin exp_en = 4'hB; exp_seg = s2; end
          default: begin exp_en = 4'h7; exp_seg = s3; end
        endcase
      end
      chk($sformatf("%s_en[%0d]", tag, i), {28'd0, en}, {28'd0, exp_en});
      chk($sformatf("%s_seg[%0d]", tag, i), {24'd0, seg}, {24'd0, exp_seg});
      chk($sformatf("%s_frame[%0d]", tag, i), {31'd0, frame}, {31'd0, (i == 15)});
    end
  endtask

  task automatic check_reset_cycle(input string tag);
    chk({tag, "_seg"},   {24'd0, seg},   32'h0000_00FF);
    chk({tag, "_en"},    {28'd0, en},    32'h0000_000F);
    chk({tag, "_frame"}, {31'd0, frame}, 32'h0000_0000);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    load  = 1'b0;
    data  = 16'h0000;
    dp    = 4'h0;
    blank = 4'h0;

    // Power-up reset.
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_cycle("por");
    end
    rst = 1'b0;
    check_frame("post_por", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    // Mid-scan reset held for 3 cycles, with a load that must be ignored.
    for (int i = 0; i < 5; i++) step();
    rst  = 1'b1;
    load = 1'b1;
    data = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_cycle("mid_rst");
    end
    rst  = 1'b0;
    load = 1'b0;
    check_frame("post_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    // Frame cadence over 10 frames.
    for (int f = 0; f < 10; f++)
      check_frame($sformatf("cad%0d", f), 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    // Full frame: 3A70 with dp on digit 1.
    do_load(16'h3A70, 4'b0010, 4'b0000);
    wait_frame();
    check_frame("full", 8'hC0, 8'h78, 8'h88, 8'hB0, 4'b0000);

    // Blank digit 3.
    do_load(16'h1234, 4'b0000, 4'b1000);
    wait_frame();
    check_frame("blank", 8'h99, 8'hB0, 8'hA4, 8'hFF, 4'b1000);

    // Two loads in one frame: only the second is displayed.
    do_load(16'h1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step();
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_frame();
    check_frame("race", 8'hA4, 8'hA4, 8'hA4, 8'hA4, 4'b0000);

    // Load exactly on the boundary cycle (state d=3, cnt=3).
    for (int i = 0; i < 15; i++) step();
    do_load(16'hFFFF, 4'b0000, 4'b0000);
    chk("bound_frame", {31'd0, frame}, 32'd1);
    check_frame("bound", 8'h8E, 8'h8E, 8'h8E, 8'h8E, 4'b0000);
    chk("bound_pend", {31'd0, dut.r_pend}, 32'd0);
    check_frame("bound2", 8'h8E, 8'h8E, 8'h8E, 8'h8E, 4'b0000);

    // Reset with pending data: 5555 must never reach the display.
    do_load(16'h5555, 4'b0000, 4'b0000);
    for (int i = 0; i < 2; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_reset_cycle("pend_rst");
    end
    rst = 1'b0;
    check_frame("pend0", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);
    check_frame("pend1", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
